// File: rtl/nor_chain_pulse_gen_if.sv
// Control/config/status bundle between a test sequencer and the NOR-chain pulse generator.
interface nor_chain_pulse_gen_if #(
    parameter int unsigned W_WIDTH = 8,
    parameter int unsigned W_COUNT = 8
);
    logic               start;
    logic               abort;
    logic [W_WIDTH-1:0] cfg_high;
    logic [W_WIDTH-1:0] cfg_low;
    logic [W_WIDTH-1:0] cfg_step;
    logic [W_WIDTH-1:0] cfg_min;
    logic [W_COUNT-1:0] cfg_count;
    logic               busy;
    logic               done;
    logic [W_COUNT-1:0] pulse_idx;

    modport master (
        output start, abort, cfg_high, cfg_low, cfg_step, cfg_min, cfg_count,
        input  busy, done, pulse_idx
    );

    modport slave (
        input  start, abort, cfg_high, cfg_low, cfg_step, cfg_min, cfg_count,
        output busy, done, pulse_idx
    );
endinterface

// File: rtl/nor_chain_pulse_gen.sv
// Registered stimulus source for the NOR fanout chain: a train of high pulses whose
// width shrinks by a fixed step per pulse down to a floor, separated by fixed low gaps.
module nor_chain_pulse_gen #(
    parameter int unsigned W_WIDTH = 8,
    parameter int unsigned W_COUNT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nor_chain_pulse_gen_if.slave   bus,
    output logic                   myin
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

    state_t             state, state_nx;
    logic [W_WIDTH-1:0] cnt, cnt_nx;
    logic [W_WIDTH-1:0] cur_high, cur_high_nx;
    logic [W_WIDTH-1:0] sh_low, sh_low_nx;
    logic [W_WIDTH-1:0] sh_step, sh_step_nx;
    logic [W_WIDTH-1:0] sh_min, sh_min_nx;
    logic [W_COUNT-1:0] sh_count, sh_count_nx;
    logic [W_COUNT-1:0] idx, idx_nx;
    logic               myin_nx, busy_r, busy_nx, done_r, done_nx;

    logic [W_WIDTH-1:0] gap_len, dec_high, floor_high, next_high;
    logic [W_COUNT-1:0] idx_inc;

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pulse_idx = idx;

    // State and all outputs are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_high <= '0;
            sh_low   <= '0;
            sh_step  <= '0;
            sh_min   <= '0;
            sh_count <= '0;
            idx      <= '0;
            myin     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cur_high <= cur_high_nx;
            sh_low   <= sh_low_nx;
            sh_step  <= sh_step_nx;
            sh_min   <= sh_min_nx;
            sh_count <= sh_count_nx;
            idx      <= idx_nx;
            myin     <= myin_nx;
            busy_r   <= busy_nx;
            done_r   <= done_nx;
        end
    end

    // Width arithmetic: saturating decrement, then clamp to max(floor, 1)
    always_comb begin
        gap_len    = (sh_low == '0) ? W_WIDTH'(1) : sh_low;
        dec_high   = (cur_high > sh_step) ? (cur_high - sh_step) : '0;
        floor_high = (sh_min == '0) ? W_WIDTH'(1) : sh_min;
        next_high  = (dec_high > floor_high) ? dec_high : floor_high;
        idx_inc    = idx + W_COUNT'(1);
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_high_nx = cur_high;
        sh_low_nx   = sh_low;
        sh_step_nx  = sh_step;
        sh_min_nx   = sh_min;
        sh_count_nx = sh_count;
        idx_nx      = idx;
        done_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    sh_low_nx   = bus.cfg_low;
                    sh_step_nx  = bus.cfg_step;
                    sh_min_nx   = bus.cfg_min;
                    sh_count_nx = bus.cfg_count;
                    cur_high_nx = bus.cfg_high;
                    idx_nx      = '0;
                    if (bus.cfg_count == '0 || bus.cfg_high == '0) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = HIGH;
                        cnt_nx   = bus.cfg_high - W_WIDTH'(1);
                    end
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_nx = FIN;
                end else if (cnt == '0) begin
                    state_nx = LOW;
                    cnt_nx   = gap_len - W_WIDTH'(1);
                end else begin
                    cnt_nx = cnt - W_WIDTH'(1);
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_nx = FIN;
                end else if (cnt == '0) begin
                    idx_nx = idx_inc;
                    if (idx_inc == sh_count) begin
                        state_nx = FIN;
                    end else begin
                        state_nx    = HIGH;
                        cur_high_nx = next_high;
                        cnt_nx      = next_high - W_WIDTH'(1);
                    end
                end else begin
                    cnt_nx = cnt - W_WIDTH'(1);
                end
            end
            FIN: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        // Outputs follow the state being entered on this edge
        myin_nx = (state_nx == HIGH);
        busy_nx = (state_nx == HIGH) || (state_nx == LOW);
    end
endmodule

// File: tb/tb_nor_chain_pulse_gen.sv
// Self-checking bench: a per-cycle expected-waveform model built from the train rules,
// compared against the DUT on every falling edge, plus directed latency/index checks.
module tb_nor_chain_pulse_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic myin;

    nor_chain_pulse_gen_if #(.W_WIDTH(8), .W_COUNT(8)) bus ();

    nor_chain_pulse_gen #(.W_WIDTH(8), .W_COUNT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .myin  (myin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       myin;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] model_idx = 8'd0;
    bit         check_en  = 1'b0;
    int         n_cmp     = 0;
    int         n_fail    = 0;

    // Per-cycle compare; with no train queued the DUT must sit idle holding pulse_idx
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (check_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{1'b0, 1'b0, 1'b0, model_idx};
            model_idx = e.idx;
            a = '{myin, bus.busy, bus.done, bus.pulse_idx};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got myin=%b busy=%b done=%b idx=%0d, need myin=%b busy=%b done=%b idx=%0d",
                         $time, a.myin, a.busy, a.done, a.idx, e.myin, e.busy, e.done, e.idx);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, got, want);
        end
    endtask

    function automatic int next_w(input int w, input int s, input int m);
        int d = (w > s) ? (w - s) : 0;
        int f = (m < 1) ? 1 : m;
        return (d > f) ? d : f;
    endfunction

    // Expected outputs for each cycle after the start-latch edge
    task automatic build(input int h, input int l, input int s, input int m,
                         input int c, input int abort_k);
        obs_t q[$];
        int   w = h;
        int   g = (l < 1) ? 1 : l;
        logic [7:0] ai;
        if (c == 0 || h == 0) begin
            q.push_back('{1'b0, 1'b0, 1'b0, 8'd0});
            q.push_back('{1'b0, 1'b0, 1'b1, 8'd0});
        end else begin
            for (int i = 0; i < c; i++) begin
                for (int k = 0; k < w; k++) q.push_back('{1'b1, 1'b1, 1'b0, 8'(i)});
                for (int k = 0; k < g; k++) q.push_back('{1'b0, 1'b1, 1'b0, 8'(i)});
                w = next_w(w, s, m);
            end
            q.push_back('{1'b0, 1'b0, 1'b0, 8'(c)});
            q.push_back('{1'b0, 1'b0, 1'b1, 8'(c)});
            if (abort_k > 0 && abort_k < q.size()) begin
                ai = q[abort_k-1].idx;
                while (q.size() > abort_k) void'(q.pop_back());
                q.push_back('{1'b0, 1'b0, 1'b0, ai});
                q.push_back('{1'b0, 1'b0, 1'b1, ai});
            end
        end
        foreach (q[i]) exp_q.push_back(q[i]);
    endtask

    task automatic run(input string name, input int h, input int l, input int s,
                       input int m, input int c, input int abort_k, input int hold,
                       input bit wiggle, input int want_done, input int want_idx);
        int got = -1;
        @(posedge clk); #2;
        bus.cfg_high  = 8'(h);
        bus.cfg_low   = 8'(l);
        bus.cfg_step  = 8'(s);
        bus.cfg_min   = 8'(m);
        bus.cfg_count = 8'(c);
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, model_idx});
        build(h, l, s, m, c, abort_k);
        for (int j = 0; j < 600; j++) begin
            @(posedge clk); #2;
            bus.start = (j + 1 < hold);
            bus.abort = (abort_k > 0 && j == abort_k - 1);
            if (wiggle) begin
                bus.cfg_high  = 8'(j + 1);
                bus.cfg_low   = 8'(j + 7);
                bus.cfg_step  = 8'(j);
                bus.cfg_min   = 8'(j + 3);
                bus.cfg_count = 8'(j + 2);
            end
            @(negedge clk);
            if (bus.done) begin
                got = j;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk({name, " done_latency"}, got, want_done);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        exp_q.delete();
        chk({name, " pulse_idx"}, int'(bus.pulse_idx), want_idx);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.cfg_high = 8'd0; bus.cfg_low = 8'd0; bus.cfg_step = 8'd0;
        bus.cfg_min = 8'd0; bus.cfg_count = 8'd0;

        // Pin the width model against hand-derived sequences
        chk("model basic w1", next_w(6, 2, 1), 4);
        chk("model basic w2", next_w(4, 2, 1), 2);
        chk("model basic w3", next_w(2, 2, 1), 1);
        chk("model floor w1", next_w(5, 3, 3), 3);
        chk("model floor w2", next_w(3, 3, 3), 3);

        #7;
        chk("reset outputs", int'({myin, bus.busy, bus.done, bus.pulse_idx}), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #2 check_en = 1'b1;
        repeat (3) @(negedge clk);

        // name, high, low, step, min, count, abort_k, hold, wiggle, done_at, idx
        run("basic",      6,   3, 2, 1, 4,  0,  1, 1'b0, 26,  4);
        run("floor",      5,   0, 3, 3, 3,  0,  1, 1'b0, 15,  3);
        run("count0",     9,   2, 1, 1, 0,  0,  1, 1'b0, 1,   0);
        run("high0",      0,   2, 1, 1, 5,  0,  1, 1'b0, 1,   0);
        run("abort",      6,   3, 2, 1, 4,  11, 1, 1'b0, 12,  1);
        run("fresh",      6,   3, 2, 1, 4,  0,  1, 1'b0, 26,  4);
        run("held_start", 6,   3, 2, 1, 4,  0,  10, 1'b1, 26, 4);
        run("max_high",   255, 1, 1, 1, 1,  0,  1, 1'b0, 257, 1);

        // Asynchronous reset in the middle of a high phase
        @(posedge clk); #2;
        bus.cfg_high = 8'd6; bus.cfg_low = 8'd3; bus.cfg_step = 8'd2;
        bus.cfg_min = 8'd1; bus.cfg_count = 8'd4; bus.start = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, model_idx});
        build(6, 3, 2, 1, 4, 0);
        @(posedge clk); #2 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        check_en = 1'b0;
        chk("pre_reset myin", int'(myin), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset outputs", int'({myin, bus.busy, bus.done, bus.pulse_idx}), 0);
        exp_q.delete();
        model_idx = 8'd0;
        #10 rst_n = 1'b1;
        @(posedge clk); #2 check_en = 1'b1;
        repeat (6) @(negedge clk);
        run("post_reset", 6, 3, 2, 1, 4, 0, 1, 1'b0, 26, 4);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
